// File: rtl/sd_digit_emitter_if.sv
// sd_digit_emitter_if
// Bundles the operand-load side and the signed-digit output side of the
// serial signed-digit emitter.
//   enable        : clock enable shared with the downstream consumer
//   load          : load request
//   vec_in_plus   : positive digit bits, bit unrolling-1 is the MSD
//   vec_in_minus  : negative digit bits, aligned with vec_in_plus
//   digit_select  : 2'b10 = +1, 2'b01 = -1, 2'b00 = 0
//   digit_valid   : digit_select carries an operand digit
//   last_digit    : high with the LSD
//   done          : one-cycle pulse after the LSD
//   busy          : operand in flight (delay prefix or streaming)
// master = emitter, slave = the block driving loads / consuming digits.
interface sd_digit_emitter_if #(
  parameter int unsigned unrolling = 64
);
  logic                 enable;
  logic                 load;
  logic [unrolling-1:0] vec_in_plus;
  logic [unrolling-1:0] vec_in_minus;
  logic [1:0]           digit_select;
  logic                 digit_valid;
  logic                 last_digit;
  logic                 done;
  logic                 busy;

  modport master (
    input  enable,
    input  load,
    input  vec_in_plus,
    input  vec_in_minus,
    output digit_select,
    output digit_valid,
    output last_digit,
    output done,
    output busy
  );

  modport slave (
    output enable,
    output load,
    output vec_in_plus,
    output vec_in_minus,
    input  digit_select,
    input  digit_valid,
    input  last_digit,
    input  done,
    input  busy
  );
endinterface

// File: rtl/sd_digit_emitter.sv
// sd_digit_emitter
// Captures a parallel redundant operand (plus/minus bit vectors) and streams
// it MSD-first, one signed digit per enabled cycle, after a prefix of
// online_delay zero digits.
// Ports:
//   clk        : rising-edge clock
//   asyn_reset : asynchronous active-high reset, aborts any stream
//   bus        : sd_digit_emitter_if master modport (enable, load, operand
//                vectors in; digit_select, digit_valid, last_digit, done,
//                busy out, all registered)
module sd_digit_emitter #(
  parameter int unsigned unrolling    = 64,
  parameter int unsigned online_delay = 2
) (
  input  logic               clk,
  input  logic               asyn_reset,
  sd_digit_emitter_if.master bus
);

  localparam int unsigned CNT_W = $clog2(unrolling + online_delay) + 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  =
    (online_delay > 0) ? CNT_W'(online_delay - 1) : '0;
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(unrolling);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    STREAM,
    DONE
  } state_t;

  state_t               state;
  logic [unrolling-1:0] sh_plus;
  logic [unrolling-1:0] sh_minus;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [1:0]           digit_select_q;
  logic                 digit_valid_q;
  logic                 last_digit_q;
  logic                 done_q;
  logic                 busy_q;
  logic [1:0]           msd_reg;
  logic [1:0]           msd_in;

  // (plus, minus) -> digit_select; a 1,1 pair cancels to zero.
  function automatic logic [1:0] normalise(input logic p, input logic m);
    return {p & ~m, m & ~p};
  endfunction

  assign msd_reg = normalise(sh_plus[unrolling-1], sh_minus[unrolling-1]);
  assign msd_in  = normalise(bus.vec_in_plus[unrolling-1],
                             bus.vec_in_minus[unrolling-1]);
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state          <= IDLE;
      sh_plus        <= '0;
      sh_minus       <= '0;
      cnt            <= '0;
      digit_select_q <= '0;
      digit_valid_q  <= 1'b0;
      last_digit_q   <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else if (bus.enable) begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.load) begin
            busy_q <= 1'b1;
            if (online_delay > 0) begin
              sh_plus        <= bus.vec_in_plus;
              sh_minus       <= bus.vec_in_minus;
              cnt            <= '0;
              state          <= DELAY;
              digit_select_q <= '0;
              digit_valid_q  <= 1'b0;
              last_digit_q   <= 1'b0;
            end else begin
              // With no prefix the first digit must appear on the cycle right
              // after the load edge, so it is taken straight from the input
              // and the shift registers start one position further on.
              sh_plus        <= bus.vec_in_plus << 1;
              sh_minus       <= bus.vec_in_minus << 1;
              cnt            <= CNT_W'(1);
              state          <= STREAM;
              digit_select_q <= msd_in;
              digit_valid_q  <= 1'b1;
              last_digit_q   <= (unrolling == 1);
            end
          end else begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            digit_select_q <= '0;
            digit_valid_q  <= 1'b0;
            last_digit_q   <= 1'b0;
          end
        end

        DELAY: begin
          if (cnt == DELAY_LAST) begin
            // Final prefix cycle: the first digit goes out on this edge so it
            // is visible exactly online_delay cycles after the load.
            state          <= STREAM;
            sh_plus        <= sh_plus << 1;
            sh_minus       <= sh_minus << 1;
            cnt            <= CNT_W'(1);
            digit_select_q <= msd_reg;
            digit_valid_q  <= 1'b1;
            last_digit_q   <= (unrolling == 1);
          end else begin
            cnt <= cnt_inc;
          end
        end

        STREAM: begin
          // cnt holds the number of digits already presented.
          if (cnt == STREAM_LAST) begin
            state          <= DONE;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
            digit_select_q <= '0;
            digit_valid_q  <= 1'b0;
            last_digit_q   <= 1'b0;
          end else begin
            sh_plus        <= sh_plus << 1;
            sh_minus       <= sh_minus << 1;
            cnt            <= cnt_inc;
            digit_select_q <= msd_reg;
            digit_valid_q  <= 1'b1;
            last_digit_q   <= (cnt_inc == STREAM_LAST);
          end
        end

        default: begin
          state          <= IDLE;
          busy_q         <= 1'b0;
          digit_select_q <= '0;
          digit_valid_q  <= 1'b0;
          last_digit_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.digit_select = digit_select_q;
  assign bus.digit_valid  = digit_valid_q;
  assign bus.last_digit   = last_digit_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/sd_digit_emitter.md
# sd_digit_emitter

Serial signed-digit source for the online multiplier datapath. Captures a parallel redundant operand (plus/minus bit vectors), then streams it MSD-first, one signed digit per enabled cycle, on the 2-bit `digit_select` encoding used by the signed-digit vector multiplier. The stream is preceded by a programmable online-delay prefix of zero digits. Sits upstream of the multiplier's digit-select input and acts as the transmitter for that interface.

## Interface

**Parameters**

- `unrolling`, default 64: digits per operand; width of the vector inputs.
- `online_delay`, default 2: number of zero-digit prefix cycles before the first real digit. May be 0.

**Ports**

- `clk`, input, 1: clock; all state changes on the rising edge.
- `asyn_reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: clock enable for all state. When low, every register holds.
- `load`, input, 1: load request.
- `vec_in_plus`, input, `unrolling`: positive digit bits; bit `unrolling-1` is the MSD.
- `vec_in_minus`, input, `unrolling`: negative digit bits, aligned with `vec_in_plus`.
- `digit_select`, output, 2: registered digit. `2'b10` = +1, `2'b01` = -1, `2'b00` = 0. `2'b11` is never driven.
- `digit_valid`, output, 1: registered; high while `digit_select` carries an operand digit.
- `last_digit`, output, 1: registered; high with the final (LSD) digit.
- `done`, output, 1: registered; one-cycle pulse after the last digit.
- `busy`, output, 1: high in `DELAY` and `STREAM`.

## Operation

**State machine: `IDLE`, `DELAY`, `STREAM`, `DONE`.** All transitions occur only on edges where `enable` = 1.

- **`IDLE`**: if `load` = 1, capture both vectors into shift registers and clear the counter.
  - Go to `DELAY` if `online_delay` > 0, otherwise go to `STREAM`.
- **`DELAY`**: drive `digit_select` = 00 and `digit_valid` = 0. Count `online_delay` cycles, then go to `STREAM`.
- **`STREAM`**: each cycle, emit the current MSD pair and shift both registers left by one.
  - After `unrolling` digits, go to `DONE`.
  - `load` is ignored in this state and in `DELAY`.
- **`DONE`**: `done` = 1 for this cycle only.
  - If `load` = 1 in this cycle, the new operand is captured exactly as in `IDLE`. This gives back-to-back operation with no `IDLE` gap.
  - Otherwise go to `IDLE`.

**Digit normalisation** (plus bit, minus bit → `digit_select`):

- 1,0 → 10
- 0,1 → 01
- 0,0 → 00
- 1,1 → 00

**Counter:** width `$clog2(unrolling+online_delay)+1`, no wrap within an operand. It is reused for both the `DELAY` count and the `STREAM` count.

**Outputs outside `STREAM`:** `digit_select` = 00, `digit_valid` = 0, `last_digit` = 0.

## Timing

- **Reset values:** state = `IDLE`; shift registers = 0; counter = 0; `digit_select` = 00; `digit_valid`, `last_digit`, `done` and `busy` all 0.
- **Reset mid-operation:** `asyn_reset` takes effect immediately, independent of `clk` and `enable`. It aborts any stream with no `done` pulse.
- **Load timing:** load accepted at enabled edge *t*.
  - Operand digits appear at outputs from cycle *t*+1+`online_delay` through *t*+`online_delay`+`unrolling`, counting only enabled cycles.
  - `last_digit` is asserted with the final digit.
  - `done` is asserted in the next enabled cycle.
- **Throughput:** one operand per `online_delay`+`unrolling`+1 enabled cycles when loads land in `DONE`.
- **`enable` low:** all outputs hold their last values, including `digit_valid`, `done` and `last_digit`. The downstream consumer must gate on the same `enable`.
- **Consumer latency:** the consumer registers `digit_select` one further cycle before use. The emitter adds no extra alignment for this.

## Test plan

Run with `unrolling` = 4 and `online_delay` = 2.

1. **Reset.** Assert `asyn_reset` between clock edges → all outputs 0 immediately. Release it, hold `load` = 0 for 10 cycles → outputs stay 0.
2. **Basic stream.** Load plus = 4'b1001, minus = 4'b0100 at edge *t*.
   - Cycles *t*+1 and *t*+2: `digit_select` = 00, `digit_valid` = 0.
   - Cycles *t*+3 to *t*+6: digits 10, 01, 00, 10 with `digit_valid` = 1; `last_digit` = 1 only at *t*+6.
   - Cycle *t*+7: `done` = 1; `busy` = 0 at *t*+7.
3. **Normalisation and ignored load.** Load plus = 4'b1111, minus = 4'b1010 → digits 00, 10, 00, 10. Pulse `load` with other data during `STREAM` → stream unchanged, no extra operand.
4. **Enable stall.** Repeat scenario 2 with `enable` = 0 for 3 cycles after the second digit → outputs frozen at 01 for those cycles. Remaining digits 00, 10 follow; `done` arrives 3 cycles late.
5. **Back-to-back.** Assert `load` in the `DONE` cycle with plus = 4'b0001, minus = 0 → next cycle starts `DELAY` with no `IDLE` cycle. Digits 00, 00, 00, 10 follow.
6. **Reset mid-operation.** Assert `asyn_reset` during the third digit of scenario 2 → outputs 0 and `busy` = 0 immediately, no `done`. A new load after release streams correctly from its MSD.
